mult_div_unit: RTL

Iterative multiply/divide unit for the single-cycle MIPS datapath. It sits beside the combinational ALU and executes MULT, MULTU, DIV and DIVU over multiple cycles into a private HI/LO register pair, using a start/busy/done handshake. Operand width is a parameter. HI and LO can also be loaded directly (MTHI/MTLO) and are always readable (MFHI/MFLO).

---
 rtl/mult_div_unit.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit with a private HI/LO pair.
// Executes MULT/MULTU/DIV/DIVU one radix-2 step per cycle and supports
// direct HI/LO loads (MTHI/MTLO) while idle.
// Ports:
//   clk, resetN          rising-edge clock, async active-low reset
//   start, opCode        request + op (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   operand1, operand2   multiplicand/dividend, multiplier/divisor
//   writeHi, writeLo     direct HI/LO load from writeData (idle only)
//   busy, done           operation in progress / one-cycle completion pulse
//   divByZero            one-cycle pulse with done for a zero divisor
//   hi, lo               HI/LO registers
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start,
  input  logic [1:0]       opCode,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic             writeHi,
  input  logic             writeLo,
  input  logic [WIDTH-1:0] writeData,
  output logic             busy,
  output logic             done,
  output logic             divByZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned DW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_FINISH  = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_is_div;
  logic             r_neg_res;   // product / quotient sign
  logic             r_neg_rem;   // remainder follows dividend sign
  logic             r_dbz;       // zero divisor detected at start
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_opnd;      // multiplicand or divisor magnitude
  logic [DW-1:0]    r_acc;       // {upper, lower} working accumulator
  logic             r_busy;
  logic             r_done;
  logic             r_div_zero;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  // Operand decode at start: magnitudes and signs
  logic             w_signed;
  logic             w_op1_neg;
  logic             w_op2_neg;
  logic [WIDTH-1:0] w_op1_mag;
  logic [WIDTH-1:0] w_op2_mag;

  assign w_signed  = ~opCode[0];
  assign w_op1_neg = w_signed & operand1[WIDTH-1];
  assign w_op2_neg = w_signed & operand2[WIDTH-1];
  assign w_op1_mag = w_op1_neg ? (~operand1 + 1'b1) : operand1;
  assign w_op2_mag = w_op2_neg ? (~operand2 + 1'b1) : operand2;

  // Multiply step: conditional add into the upper half, then shift right
  logic [WIDTH:0]   w_mul_sum;
  logic [DW-1:0]    w_mul_next;

  assign w_mul_sum  = {1'b0, r_acc[DW-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opnd : '0)};
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring divide step: shift in the next dividend bit, trial subtract
  logic [WIDTH:0]   w_div_try;
  logic [WIDTH:0]   w_div_diff;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_div_rem;
  logic [DW-1:0]    w_div_next;

  assign w_div_try  = {r_acc[DW-1:WIDTH], r_acc[WIDTH-1]};
  assign w_div_diff = w_div_try - {1'b0, r_opnd};
  assign w_div_ge   = ~w_div_diff[WIDTH];
  assign w_div_rem  = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_try[WIDTH-1:0];
  assign w_div_next = {w_div_rem, r_acc[WIDTH-2:0], w_div_ge};

  // Sign correction applied in FINISH
  logic [DW-1:0]    w_prod;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;

  assign w_prod = r_neg_res ? (~r_acc + 1'b1) : r_acc;
  assign w_quo  = r_neg_res ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_rem ? (~r_acc[DW-1:WIDTH] + 1'b1) : r_acc[DW-1:WIDTH];

  // Control and datapath registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state    <= S_IDLE;
      r_is_div   <= 1'b0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_dbz      <= 1'b0;
      r_cnt      <= '0;
      r_opnd     <= '0;
      r_acc      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_is_div  <= opCode[1];
            r_neg_res <= w_op1_neg ^ w_op2_neg;
            r_neg_rem <= w_op1_neg;
            r_dbz     <= opCode[1] && (operand2 == '0);
            r_cnt     <= '0;
            r_opnd    <= opCode[1] ? w_op2_mag : w_op1_mag;
            r_acc     <= {{WIDTH{1'b0}}, (opCode[1] ? w_op1_mag : w_op2_mag)};
            r_busy    <= 1'b1;
            r_state   <= S_COMPUTE;
          end else begin
            if (writeHi) r_hi <= writeData;
            if (writeLo) r_lo <= writeData;
          end
        end
        S_COMPUTE: begin
          // A zero divisor skips the iterations and spends one cycle here
          if (r_dbz) begin
            r_state <= S_FINISH;
          end else begin
            r_acc <= r_is_div ? w_div_next : w_mul_next;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CW'(WIDTH - 1)) r_state <= S_FINISH;
          end
        end
        S_FINISH: begin
          if (r_dbz) begin
            r_div_zero <= 1'b1;
          end else if (r_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end else begin
            r_hi <= w_prod[DW-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign divByZero = r_div_zero;
  assign hi        = r_hi;
  assign lo        = r_lo;

endmodule
